// File: rtl/ioctl_rom_sink_if.sv
// Bundle between hps_io's download stream, the ROM sink and the SDRAM write port.
// Both sides use valid/ready semantics. A byte transfers on a rising edge where
// ioctl_wr & ioctl_download & !ioctl_wait. A write transfers on the edge where
// o_SDRAM_REQ & i_SDRAM_ACK, and REQ/ADDR/DATA/BE hold steady until then.
interface ioctl_rom_sink_if #(
  parameter int AW = 24
);
  logic [15:0]   ioctl_index;
  logic          ioctl_download;
  logic [26:0]   ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          ioctl_wait;
  logic          o_SDRAM_REQ;
  logic [AW-1:0] o_SDRAM_ADDR;
  logic [15:0]   o_SDRAM_DATA;
  logic [1:0]    o_SDRAM_BE;
  logic          i_SDRAM_ACK;

  modport master (
    output ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_ACK,
    input  ioctl_wait, o_SDRAM_REQ, o_SDRAM_ADDR, o_SDRAM_DATA, o_SDRAM_BE
  );

  modport slave (
    input  ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_ACK,
    output ioctl_wait, o_SDRAM_REQ, o_SDRAM_ADDR, o_SDRAM_DATA, o_SDRAM_BE
  );
endinterface

// File: rtl/ioctl_rom_sink.sv
// Packs a byte-wide hps_io ROM download into 16-bit SDRAM word writes and
// captures a small DIP-switch image from a second download index.
module ioctl_rom_sink #(
  parameter logic [15:0] ROM_INDEX = 16'd0,
  parameter logic [15:0] DIP_INDEX = 16'd254,
  parameter int          AW        = 24
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_RST_n,
  ioctl_rom_sink_if.slave   bus,
  output logic [63:0]       o_DIPSW,
  output logic              o_ROM_READY,
  output logic              o_LOADING,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FLUSH = 2'd2, FINISH = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    be_q, be_d;
  logic          wait_q, wait_d;
  logic          pend_v_q, pend_v_d;
  logic [AW-1:0] pend_a_q, pend_a_d;
  logic [7:0]    pend_b_q, pend_b_d;
  logic          hold_v_q, hold_v_d;
  logic [AW-1:0] hold_w_q, hold_w_d;
  logic          hold_hi_q, hold_hi_d;
  logic [7:0]    hold_b_q, hold_b_d;
  logic          end_q, end_d;
  logic          loading_q;
  logic          ready_q, ready_d;
  logic [63:0]   dip_q, dip_d;

  logic          rom_active, take, rom_take, dip_take, dl_start, dl_end;
  logic          src_v, src_hi;
  logic [AW-1:0] src_w;
  logic [7:0]    src_b;

  assign rom_active = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign take       = bus.ioctl_wr && bus.ioctl_download && !wait_q;
  assign rom_take   = take && (bus.ioctl_index == ROM_INDEX);
  assign dip_take   = take && (bus.ioctl_index == DIP_INDEX) && (bus.ioctl_addr[26:3] == '0);
  assign dl_start   = rom_active && !loading_q;
  assign dl_end     = loading_q && !rom_active;

  // A byte parked behind a flush is replayed before any new byte is taken.
  assign src_v  = hold_v_q || rom_take;
  assign src_w  = hold_v_q ? hold_w_q  : bus.ioctl_addr[AW:1];
  assign src_hi = hold_v_q ? hold_hi_q : bus.ioctl_addr[0];
  assign src_b  = hold_v_q ? hold_b_q  : bus.ioctl_data;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    pend_v_d  = pend_v_q;
    pend_a_d  = pend_a_q;
    pend_b_d  = pend_b_q;
    hold_v_d  = hold_v_q;
    hold_w_d  = hold_w_q;
    hold_hi_d = hold_hi_q;
    hold_b_d  = hold_b_q;
    end_d     = end_q || dl_end;
    ready_d   = ready_q;
    dip_d     = dip_q;

    case (state_q)
      IDLE: begin
        if (src_v) begin
          hold_v_d = 1'b0;
          if (pend_v_q && (src_w != pend_a_q)) begin
            state_d   = FLUSH;
            hold_v_d  = 1'b1;
            hold_w_d  = src_w;
            hold_hi_d = src_hi;
            hold_b_d  = src_b;
          end else if (!src_hi) begin
            pend_v_d = 1'b1;
            pend_a_d = src_w;
            pend_b_d = src_b;
          end else begin
            state_d  = WRITE;
            req_d    = 1'b1;
            addr_d   = src_w;
            data_d   = {src_b, pend_v_q ? pend_b_q : 8'h00};
            be_d     = pend_v_q ? 2'b11 : 2'b10;
            pend_v_d = 1'b0;
          end
        end else if (end_d) begin
          if (pend_v_q) begin
            state_d = FLUSH;
          end else begin
            state_d = FINISH;
            end_d   = 1'b0;
          end
        end
      end
      FLUSH: begin
        state_d  = WRITE;
        req_d    = 1'b1;
        addr_d   = pend_a_q;
        data_d   = {8'h00, pend_b_q};
        be_d     = 2'b01;
        pend_v_d = 1'b0;
      end
      WRITE: begin
        if (bus.i_SDRAM_ACK) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      FINISH: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (dl_start) ready_d = 1'b0;
    if (dip_take) dip_d[{bus.ioctl_addr[2:0], 3'b000} +: 8] = bus.ioctl_data;

    // Registered so the stream stalls the very cycle after a word is completed.
    wait_d = (state_d != IDLE) || hold_v_d || end_d;
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (!i_EMU_RST_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      wait_q    <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_a_q  <= '0;
      pend_b_q  <= '0;
      hold_v_q  <= 1'b0;
      hold_w_q  <= '0;
      hold_hi_q <= 1'b0;
      hold_b_q  <= '0;
      end_q     <= 1'b0;
      loading_q <= 1'b0;
      ready_q   <= 1'b0;
      dip_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      wait_q    <= wait_d;
      pend_v_q  <= pend_v_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      hold_v_q  <= hold_v_d;
      hold_w_q  <= hold_w_d;
      hold_hi_q <= hold_hi_d;
      hold_b_q  <= hold_b_d;
      end_q     <= end_d;
      loading_q <= rom_active;
      ready_q   <= ready_d;
      dip_q     <= dip_d;
    end
  end

  assign bus.ioctl_wait   = wait_q;
  assign bus.o_SDRAM_REQ  = req_q;
  assign bus.o_SDRAM_ADDR = addr_q;
  assign bus.o_SDRAM_DATA = data_q;
  assign bus.o_SDRAM_BE   = be_q;
  assign o_DIPSW          = dip_q;
  assign o_ROM_READY      = ready_q;
  assign o_LOADING        = loading_q;
  assign state_dbg        = state_q;
endmodule

// File: doc/ioctl_rom_sink.md
IOCTL_ROM_SINK -- requirements
Module: ioctl_rom_sink

Interface
REQ-001 Parameter ROM_INDEX, default 16'd0, ioctl_index value routed to SDRAM.
REQ-002 Parameter DIP_INDEX, default 16'd254, ioctl_index value routed to the DIP register.
REQ-003 Parameter AW, default 24, SDRAM word-address width.
REQ-004 i_EMU_MCLK  in  1  sole clock; all logic on its rising edge.
REQ-005 i_EMU_RST_n  in  1  synchronous active-low reset.
REQ-006 ioctl_index, ioctl_download, ioctl_addr[26:0], ioctl_data[7:0], ioctl_wr  in  download stream from hps_io.
REQ-007 ioctl_wait  out  1  back-pressure to hps_io.
REQ-008 o_SDRAM_REQ  out  1; o_SDRAM_ADDR  out  AW (word address); o_SDRAM_DATA  out  16; o_SDRAM_BE  out  2 (byte enables).
REQ-009 i_SDRAM_ACK  in  1  one-cycle write-complete pulse from SDRAM controller.
REQ-010 o_DIPSW  out  64  DIP byte image; o_ROM_READY  out  1  ROM fully written; o_LOADING  out  1  ROM download active.

Function
REQ-011 A byte is accepted when ioctl_wr=1 and ioctl_download=1 and ioctl_wait=0 in the same cycle.
REQ-012 ROM bytes: word address = ioctl_addr[AW:1]; ioctl_addr[0]=0 goes to DATA[7:0]/BE[0], =1 to DATA[15:8]/BE[1] (little-endian).
REQ-013 Byte with ioctl_addr[0]=0 is latched as pending; no SDRAM cycle, no wait.
REQ-014 Byte with ioctl_addr[0]=1 matching the pending word issues one write with BE=2'b11; without pending byte, BE=2'b10.
REQ-015 Accepted byte with a different word address than a pending byte: pending byte is first written with BE=2'b01, then the new byte processed per REQ-013/014.
REQ-016 FSM states IDLE, WRITE, FLUSH, FINISH; IDLE->WRITE on word completion; WRITE->IDLE on i_SDRAM_ACK; IDLE->FLUSH on REQ-015 or download end with pending byte; FLUSH->WRITE; IDLE->FINISH on download end with nothing pending; FINISH->IDLE after one cycle.
REQ-017 o_SDRAM_REQ rises the cycle after the completing byte is accepted and holds until the cycle i_SDRAM_ACK=1 is sampled; ADDR/DATA/BE stable while REQ=1.
REQ-018 ioctl_wait=1 in every state except IDLE, and combinationally-registered so it is high the cycle after a completing byte; at most one SDRAM write outstanding.
REQ-019 i_SDRAM_ACK while REQ=0 is ignored.
REQ-020 Download end = ioctl_download falling edge while ioctl_index==ROM_INDEX; a byte accepted in that same cycle is processed before the flush.
REQ-021 o_LOADING follows ioctl_download & index==ROM_INDEX, registered one cycle.
REQ-022 o_ROM_READY cleared on ROM download rising edge; set in FINISH (all writes acked); sticky otherwise.
REQ-023 DIP_INDEX bytes: ioctl_addr[2:0] selects byte of o_DIPSW (byte 0 = [7:0]); ioctl_addr>=8 ignored; never asserts ioctl_wait; o_DIPSW unaffected by ROM downloads.
REQ-024 Bytes with any other index are ignored; no wait, no SDRAM activity.

Reset
REQ-025 Reset: state IDLE, o_SDRAM_REQ=0, ioctl_wait=0, pending cleared, o_ROM_READY=0, o_LOADING=0, o_DIPSW=64'h0, ADDR/DATA/BE=0.
REQ-026 Reset mid-write drops REQ next cycle; a later stray ACK has no effect.

Verification
REQ-027 ROM bytes 0x11@0, 0x22@1 -> one write ADDR=0, DATA=16'h2211, BE=11; wait high until ACK.
REQ-028 ROM bytes 0x33@4 then 0x44@8 -> write ADDR=2 DATA[7:0]=0x33 BE=01, then pending 0x44 at word 4.
REQ-029 3-byte ROM download 0xAA,0xBB,0xCC @0..2 then download falls -> writes (0,16'hBBAA,11),(1,xxCC,01); o_ROM_READY=1 after second ACK.
REQ-030 DIP index, bytes 0x5A@0, 0xC3@7, 0xFF@8 -> o_DIPSW=64'hC300_0000_0000_005A; no REQ, wait never high.
REQ-031 Reset asserted while REQ=1 -> REQ=0, wait=0, o_ROM_READY=0 next cycle; following ACK produces no state change.
